// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types, constants and helpers for the data-memory port arbiter
// Purpose: arbiter state encoding, latched burst descriptor, DM geometry and small
//   helpers for byte-strobe expansion and port one-hot encoding.
package dm_arb_pkg;

  localparam int          LEN_W   = 4;
  localparam logic [31:0] DM_SIZE = 32'h0002_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             we;
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
  } burst_req_t;

  // SRAM bit mask is active low: a strobed byte clears its eight mask bits.
  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] bweb;
    for (int i = 0; i < 4; i++) begin
      bweb[i*8 +: 8] = {8{~strb[i]}};
    end
    return bweb;
  endfunction

  function automatic logic [1:0] port_oh(input logic port);
    return {port, ~port};
  endfunction

endpackage

// File: rtl/dm_bank_decode.sv
// rtl/dm_bank_decode.sv - byte address to SRAM bank / word address decode
// Purpose: maps a byte address onto the two-bank DM pair.
// Ports: addr (in, 32) byte address; bank (out) bank select; word_a (out, BANK_ABITS)
//   word address within the bank; out_of_range (out) address not inside DM.
module dm_bank_decode
  import dm_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          BANK_ABITS = 14
) (
  input  logic [31:0]           addr,
  output logic                  bank,
  output logic [BANK_ABITS-1:0] word_a,
  output logic                  out_of_range
);

  logic [31:0] off;

  // Addresses below BASE_ADDR wrap to a huge offset and so fall out of range too.
  assign off          = addr - BASE_ADDR;
  assign out_of_range = (off >= DM_SIZE);
  assign bank         = off[BANK_ABITS+2];
  assign word_a       = off[BANK_ABITS+1:2];

endmodule

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - round-robin burst arbiter sharing the DM SRAM bank pair
// Purpose: grants whole bursts to port 0 (CPU) or port 1 (VPU), sequences SRAM pins
//   per beat and returns read data one cycle after each read beat.
// Ports: clk, rst (async, active high); m_req/m_we/m_beat/m_gnt/m_done/m_rvalid/m_err
//   one bit per port; m_addr/m_wdata 32 bits per port, m_len/m_wstrb 4 bits per port,
//   port 1 in the upper slice; m_rdata shared read bus; sram_ceb per-bank enable,
//   sram_web/sram_a/sram_d/sram_bweb shared pins; sram_q bank 1 Q [63:32], bank 0 Q [31:0].
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          BANK_ABITS = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_req,
  input  logic [1:0]            m_we,
  input  logic [63:0]           m_addr,
  input  logic [2*LEN_W-1:0]    m_len,
  input  logic [1:0]            m_beat,
  input  logic [63:0]           m_wdata,
  input  logic [7:0]            m_wstrb,
  output logic [1:0]            m_gnt,
  output logic [1:0]            m_done,
  output logic [1:0]            m_rvalid,
  output logic [31:0]           m_rdata,
  output logic [1:0]            m_err,
  output logic [1:0]            sram_ceb,
  output logic                  sram_web,
  output logic [BANK_ABITS-1:0] sram_a,
  output logic [31:0]           sram_d,
  output logic [31:0]           sram_bweb,
  input  logic [63:0]           sram_q
);

  state_t           state_q, state_d;
  logic             g_q, g_d;
  logic             rr_q, rr_d;
  burst_req_t       burst_q, burst_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rvld_q, rvld_d;
  logic             rerr_q, rerr_d;
  logic             rbank_q, rbank_d;

  logic                  win;
  logic                  beat;
  logic                  last;
  logic [1:0]            gnt_oh;
  logic                  bank;
  logic [BANK_ABITS-1:0] word_a;
  logic                  oor;

  dm_bank_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .BANK_ABITS (BANK_ABITS)
  ) u_decode (
    .addr         (burst_q.addr),
    .bank         (bank),
    .word_a       (word_a),
    .out_of_range (oor)
  );

  assign gnt_oh = port_oh(g_q);
  assign last   = (cnt_q == burst_q.len);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    beat    = 1'b0;
    // Pointer port wins when it requests; otherwise the other port must be requesting.
    win     = m_req[rr_q] ? rr_q : ~rr_q;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          g_d          = win;
          burst_d.we   = m_we[win];
          burst_d.addr = (win ? m_addr[63:32] : m_addr[31:0]) & ~32'h3;
          burst_d.len  = win ? m_len[2*LEN_W-1:LEN_W] : m_len[LEN_W-1:0];
          cnt_d        = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        beat = m_beat[g_q];
        if (beat) begin
          burst_d.addr = burst_q.addr + 32'd4;
          if (last) begin
            state_d = IDLE;
            rr_d    = ~g_q;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins follow the beat combinationally; out-of-range beats leave both banks off.
  always_comb begin
    sram_ceb  = 2'b11;
    sram_web  = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    sram_bweb = '1;
    if (beat && !oor) begin
      sram_ceb = bank ? 2'b01 : 2'b10;
      sram_a   = word_a;
      if (burst_q.we) begin
        sram_web  = 1'b0;
        sram_d    = g_q ? m_wdata[63:32] : m_wdata[31:0];
        sram_bweb = strb_to_bweb(g_q ? m_wstrb[7:4] : m_wstrb[3:0]);
      end
    end
  end

  assign rvld_d  = (beat && !burst_q.we) ? gnt_oh : 2'b00;
  assign rerr_d  = oor;
  assign rbank_d = bank;

  assign m_gnt    = (state_q == GRANT) ? gnt_oh : 2'b00;
  assign m_done   = (beat && last) ? gnt_oh : 2'b00;
  assign m_err    = (beat && oor) ? gnt_oh : 2'b00;
  assign m_rvalid = rvld_q;
  // Out-of-range reads still return a beat, carrying zero instead of bank Q.
  assign m_rdata  = (|rvld_q && !rerr_q) ? (rbank_q ? sram_q[63:32] : sram_q[31:0]) : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      rr_q    <= 1'b0;
      burst_q <= '0;
      cnt_q   <= '0;
      rvld_q  <= 2'b00;
      rerr_q  <= 1'b0;
      rbank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rerr_q  <= rerr_d;
      rbank_q <= rbank_d;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - self-checking bench for dm_port_arbiter
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req, m_we, m_beat;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_len, m_wstrb;
  logic [1:0]  m_gnt, m_done, m_rvalid, m_err, sram_ceb;
  logic [31:0] m_rdata, sram_d, sram_bweb;
  logic        sram_web;
  logic [13:0] sram_a;
  logic [31:0] q0 = 32'h0, q1 = 32'h0;
  logic [63:0] sram_q;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int          p;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          p;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [15:0] pat;
    logic [3:0]  strb;
    logic [1:0]  x_ceb;
    logic [13:0] x_a;
    logic [1:0]  x_err;
  } vec_t;
  vec_t tbl[11];

  logic [31:0] smem [int];
  logic [31:0] rmem [int];
  int          sm_wo;
  logic [31:0] sm_old;

  assign sram_q = {q1, q0};

  dm_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_len     (m_len),
    .m_beat    (m_beat),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_gnt     (m_gnt),
    .m_done    (m_done),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_bweb (sram_bweb),
    .sram_q    (sram_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int wo);
    return 32'h5A00_0000 ^ (wo * 32'h0001_0003);
  endfunction

  function automatic logic [31:0] bweb_of(input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{~s[i]}};
    return r;
  endfunction

  function automatic logic [31:0] rd_ref(input int wo);
    return rmem.exists(wo) ? rmem[wo] : init_word(wo);
  endfunction

  // Synchronous SRAM bank pair: Q updates at the clock edge after a read enable.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (!sram_ceb[b]) begin
        sm_wo  = b * 16384 + int'(sram_a);
        sm_old = smem.exists(sm_wo) ? smem[sm_wo] : init_word(sm_wo);
        if (!sram_web) smem[sm_wo] = (sm_old & sram_bweb) | (sram_d & ~sram_bweb);
        else if (b == 0) q0 <= sm_old;
        else q1 <= sm_old;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Read-return checker: exactly one cycle after each read beat, nothing otherwise.
  always @(negedge clk) begin
    if (rst) begin
      chk("rvalid_in_reset", m_rvalid, 2'b00);
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rvalid", m_rvalid, 2'b01 << sb[0].p);
      chk("rdata", m_rdata, sb[0].data);
      void'(sb.pop_front());
    end else begin
      chk("rvalid_idle", m_rvalid, 2'b00);
    end
  end

  // One granted cycle, entered at posedge+1; leaves at the next posedge+1.
  task automatic beat_cycle(input int p, input bit we, input logic [31:0] wa, input bit bt,
                            input bit last, input logic [3:0] strb,
                            output logic [1:0] c, output logic [13:0] a, output logic [1:0] e);
    logic [31:0] off, wd;
    logic        oor;
    logic [1:0]  oh;
    int          wo;
    oh  = 2'b01 << p;
    off = wa - 32'h0001_0000;
    oor = (off >= 32'h0002_0000);
    wo  = int'(off[16:2]);
    wd  = $urandom;
    m_beat = 2'b00;
    m_beat[p]   = bt;
    m_beat[1-p] = 1'($urandom_range(0, 1));
    m_wdata[p*32 +: 32] = wd;
    m_wstrb[p*4 +: 4]   = strb;
    @(negedge clk);
    c = sram_ceb;
    a = sram_a;
    e = m_err;
    chk("gnt", m_gnt, oh);
    if (!bt) begin
      chk("bubble_ceb", sram_ceb, 2'b11);
      chk("bubble_done", m_done, 2'b00);
    end else begin
      chk("ceb", sram_ceb, oor ? 2'b11 : (off[16] ? 2'b01 : 2'b10));
      chk("sram_a", sram_a, oor ? 14'h0 : off[15:2]);
      chk("web", sram_web, !(we && !oor));
      chk("bweb", sram_bweb, (we && !oor) ? bweb_of(strb) : 32'hFFFF_FFFF);
      chk("sram_d", sram_d, (we && !oor) ? wd : 32'h0);
      chk("err", m_err, oor ? oh : 2'b00);
      chk("done", m_done, last ? oh : 2'b00);
      if (we && !oor) rmem[wo] = (rd_ref(wo) & bweb_of(strb)) | (wd & ~bweb_of(strb));
      else if (!we) sb.push_back('{p, oor ? 32'h0 : rd_ref(wo), cyc + 1});
    end
    @(posedge clk); #1;
  endtask

  // Whole burst from an idle arbiter; pat bit i = beat in the i-th granted cycle.
  task automatic burst(input int p, input bit we, input logic [31:0] addr, input logic [3:0] len,
                       input logic [15:0] pat, input logic [3:0] strb,
                       output logic [1:0] ceb0, output logic [13:0] a0, output logic [1:0] err0);
    int          k, i, w;
    logic [1:0]  c, e;
    logic [13:0] a;
    logic [31:0] wa;
    bit          bt;
    ceb0 = 2'bxx; a0 = 'x; err0 = 2'bxx;
    m_req = 2'b00;
    m_req[p] = 1'b1;
    m_we[p]  = we;
    m_addr[p*32 +: 32] = addr;
    m_len[p*4 +: 4]    = len;
    w = 0;
    while (m_gnt !== (2'b01 << p) && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    chk("gnt_latency", w, 1);
    // Request fields change after the grant; the latched burst must not follow them.
    m_req = 2'b00;
    m_we[p] = ~we;
    m_addr[p*32 +: 32] = $urandom;
    m_len[p*4 +: 4]    = 4'($urandom);
    wa = addr & ~32'h3;
    k = 0;
    i = 0;
    while (k <= int'(len) && i < 40) begin
      bt = (i < 16) ? pat[i] : 1'b1;
      beat_cycle(p, we, wa, bt, bt && (k == int'(len)), strb, c, a, e);
      if (bt) begin
        if (k == 0) begin ceb0 = c; a0 = a; err0 = e; end
        wa += 4;
        k++;
      end
      i++;
    end
    m_beat = 2'b00;
    chk("gnt_release", m_gnt, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  c, e;
    logic [13:0] a;
    logic [31:0] wa;

    tbl[0]  = '{0, 1'b0, 32'h0001_0000, 4'd3,  16'hFFFF, 4'hF,    2'b10, 14'h0000, 2'b00};
    tbl[1]  = '{1, 1'b1, 32'h0002_0004, 4'd0,  16'hFFFF, 4'b0101, 2'b01, 14'h0001, 2'b00};
    tbl[2]  = '{0, 1'b0, 32'h0002_0004, 4'd2,  16'h000D, 4'hF,    2'b01, 14'h0001, 2'b00};
    tbl[3]  = '{1, 1'b0, 32'h0003_0000, 4'd0,  16'hFFFF, 4'hF,    2'b11, 14'h0000, 2'b10};
    tbl[4]  = '{0, 1'b1, 32'h0001_FFF8, 4'd3,  16'hFFFF, 4'hF,    2'b10, 14'h3FFE, 2'b00};
    tbl[5]  = '{1, 1'b0, 32'h0001_FFF8, 4'd3,  16'hFFFF, 4'hF,    2'b10, 14'h3FFE, 2'b00};
    tbl[6]  = '{0, 1'b1, 32'h0002_FFFC, 4'd1,  16'hFFFF, 4'b0000, 2'b01, 14'h3FFF, 2'b00};
    tbl[7]  = '{1, 1'b0, 32'h0001_0103, 4'd15, 16'hFFFF, 4'hF,    2'b10, 14'h0040, 2'b00};
    tbl[8]  = '{0, 1'b0, 32'h0000_FFFC, 4'd1,  16'h0005, 4'hF,    2'b11, 14'h0000, 2'b01};
    tbl[9]  = '{1, 1'b1, 32'h0002_FFF8, 4'd1,  16'h0009, 4'b1010, 2'b01, 14'h3FFE, 2'b00};
    tbl[10] = '{0, 1'b0, 32'hFFFF_FFFC, 4'd1,  16'hFFFF, 4'hF,    2'b11, 14'h0000, 2'b01};

    m_req = 2'b00; m_we = 2'b00; m_beat = 2'b00;
    m_addr = 64'h0; m_wdata = 64'h0; m_len = 8'h0; m_wstrb = 8'h0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", m_gnt, 2'b00);
    chk("rst_done", m_done, 2'b00);
    chk("rst_err", m_err, 2'b00);
    chk("rst_rdata", m_rdata, 32'h0);
    chk("rst_ceb", sram_ceb, 2'b11);
    chk("rst_web", sram_web, 1'b1);
    chk("rst_a", sram_a, 14'h0);
    chk("rst_d", sram_d, 32'h0);
    chk("rst_bweb", sram_bweb, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both ports keep requesting: P0 first after reset, then alternation with one idle cycle.
    m_req = 2'b11; m_we = 2'b11; m_wstrb = 8'h00; m_len = 8'h00;
    m_addr = {32'h0002_0000, 32'h0001_0008};
    for (int r = 0; r < 3; r++) begin
      int g;
      g = (r == 1) ? 1 : 0;
      @(posedge clk); #1;
      m_beat = 2'b11;
      @(negedge clk);
      chk("rr_gnt", m_gnt, 2'b01 << g);
      chk("rr_done", m_done, 2'b01 << g);
      chk("rr_ceb", sram_ceb, g ? 2'b01 : 2'b10);
      chk("rr_a", sram_a, g ? 14'h0 : 14'h2);
      @(posedge clk); #1;
      m_beat = 2'b00;
      if (r == 2) m_req = 2'b00;
      chk("rr_idle_gap", m_gnt, 2'b00);
    end

    // Single-port bursts from the table
    foreach (tbl[i]) begin
      burst(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].len, tbl[i].pat, tbl[i].strb, c, a, e);
      chk($sformatf("tbl%0d_ceb0", i), c, tbl[i].x_ceb);
      chk($sformatf("tbl%0d_a0", i), a, tbl[i].x_a);
      chk($sformatf("tbl%0d_err0", i), e, tbl[i].x_err);
    end

    // Async reset three beats into a len=7 read burst
    m_req = 2'b01; m_we = 2'b00; m_addr[31:0] = 32'h0001_0000; m_len[3:0] = 4'd7;
    @(posedge clk); #1;
    m_req = 2'b00;
    chk("rstb_gnt", m_gnt, 2'b01);
    wa = 32'h0001_0000;
    for (int k = 0; k < 3; k++) begin
      beat_cycle(0, 1'b0, wa, 1'b1, 1'b0, 4'hF, c, a, e);
      wa += 4;
    end
    m_beat = 2'b01;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rstb_gnt_drop", m_gnt, 2'b00);
    chk("rstb_ceb_drop", sram_ceb, 2'b11);
    chk("rstb_rvalid_drop", m_rvalid, 2'b00);
    chk("rstb_done", m_done, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    m_beat = 2'b00;
    burst(1, 1'b0, 32'h0001_0000, 4'd1, 16'hFFFF, 4'hF, c, a, e);
    chk("post_rst_ceb0", c, 2'b10);
    chk("post_rst_a0", a, 14'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
